mult_datapath: RTL and testbench

Shift-add multiplier datapath driven by the `Control` sequencer. It holds the 32-bit multiplicand and the 64-bit product/multiplier register, and executes the load, add-store and shift micro-operations the sequencer encodes on `wrctrl`, `strctrl` and `addctrl`. It returns the current multiplier LSB on `lsb` to close the loop, and latches the final product when the sequencer raises `ready`.

---
 rtl/mult_datapath.sv | 70 +++++++
 tb/tb_mult_datapath.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mult_datapath.sv
// mult_datapath: shift-add multiplier datapath executing load/store/shift micro-ops from the sequencer
module mult_datapath #(
  parameter int         WIDTH    = 32,
  parameter logic [5:0] ADD_CODE = 6'd27
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wrctrl,
  input  logic               strctrl,
  input  logic [5:0]         addctrl,
  input  logic               ready,
  input  logic [WIDTH-1:0]   multiplicand_in,
  input  logic [WIDTH-1:0]   multiplier_in,
  output logic               lsb,
  output logic [2*WIDTH-1:0] product,
  output logic               product_valid
);
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               carry_q, carry_d, pend_q, pend_d, ready_q;
  logic [5:0]         shift_cnt_q, shift_cnt_d;
  logic [WIDTH:0]     alu;
  // Pass keeps the upper half and forces the carry-in of the next shift to zero
  assign alu = (addctrl == ADD_CODE) ? {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q}
                                     : {1'b0, prod_q[2*WIDTH-1:WIDTH]};
  assign lsb = prod_q[0];
  always_comb begin
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    carry_d     = carry_q;
    pend_d      = pend_q;
    shift_cnt_d = shift_cnt_q;
    if (wrctrl) begin
      mcand_d     = multiplicand_in;
      prod_d      = {{WIDTH{1'b0}}, multiplier_in};
      carry_d     = 1'b0;
      pend_d      = 1'b0;
      shift_cnt_d = '0;
    end else if (strctrl) begin
      {carry_d, prod_d[2*WIDTH-1:WIDTH]} = alu;
      pend_d = 1'b1;
    end else if (pend_q) begin
      prod_d      = {carry_q, prod_q[2*WIDTH-1:1]};
      carry_d     = 1'b0;
      pend_d      = 1'b0;
      shift_cnt_d = (shift_cnt_q == 6'(WIDTH)) ? shift_cnt_q : shift_cnt_q + 6'd1;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_q       <= '0;
      prod_q        <= '0;
      carry_q       <= 1'b0;
      pend_q        <= 1'b0;
      ready_q       <= 1'b0;
      shift_cnt_q   <= '0;
      product       <= '0;
      product_valid <= 1'b0;
    end else begin
      mcand_q       <= mcand_d;
      prod_q        <= prod_d;
      carry_q       <= carry_d;
      pend_q        <= pend_d;
      shift_cnt_q   <= shift_cnt_d;
      ready_q       <= ready;
      product_valid <= ready && !ready_q;
      if (ready && !ready_q) product <= prod_q;
    end
  end
endmodule

// File: tb/tb_mult_datapath.sv
// tb_mult_datapath: directed checks of the shift-add multiplier datapath
module tb_mult_datapath;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wrctrl = 1'b0, strctrl = 1'b0, ready = 1'b0;
  logic [5:0]  addctrl = '0;
  logic [31:0] multiplicand_in = '0, multiplier_in = '0;
  logic        lsb;
  logic [63:0] product;
  logic        product_valid;
  int          total = 0, bad = 0;

  mult_datapath dut (
    .clk(clk), .reset(reset), .wrctrl(wrctrl), .strctrl(strctrl), .addctrl(addctrl),
    .ready(ready), .multiplicand_in(multiplicand_in), .multiplier_in(multiplier_in),
    .lsb(lsb), .product(product), .product_valid(product_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] b);
    wrctrl = 1'b1; multiplicand_in = a; multiplier_in = b;
    tick();
    wrctrl = 1'b0;
  endtask

  task automatic run_bits(input int n);
    for (int i = 0; i < n; i++) begin
      strctrl = 1'b1; addctrl = lsb ? 6'd27 : 6'd0;
      tick();
      strctrl = 1'b0; addctrl = 6'd0;
      tick();
    end
  endtask

  task automatic capture(input string tag, input logic [63:0] exp);
    ready = 1'b1;
    tick();
    chk({tag, "_product"}, product, exp);
    chk({tag, "_valid"}, {63'd0, product_valid}, 64'd1);
    ready = 1'b0;
    tick();
    chk({tag, "_valid_drop"}, {63'd0, product_valid}, 64'd0);
  endtask

  initial begin
    logic [3:0]  exp_lsb;
    logic [63:0] saved;
    int          pulses;
    exp_lsb = 4'b1011;
    #2;
    chk("rst_product", product, 64'd0);
    chk("rst_valid", {63'd0, product_valid}, 64'd0);
    chk("rst_lsb", {63'd0, lsb}, 64'd0);
    #5 reset = 1'b1;
    tick();

    // basic 6 x 11
    load(32'd6, 32'd11);
    for (int i = 0; i < 32; i++) begin
      if (i < 4) chk($sformatf("lsb_seq%0d", i), {63'd0, lsb}, {63'd0, exp_lsb[i]});
      run_bits(1);
    end
    chk("basic_prod_q", dut.prod_q, 64'd66);
    capture("basic", 64'd66);

    // carry path
    load(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_bits(32);
    chk("carry_prod_q", dut.prod_q, 64'hFFFF_FFFE_0000_0001);
    capture("carry", 64'hFFFF_FFFE_0000_0001);

    // idle hold then one store/shift
    load(32'd5, 32'hA5);
    repeat (10) tick();
    chk("idle_hold", dut.prod_q, 64'hA5);
    strctrl = 1'b1; addctrl = 6'd0;
    tick();
    strctrl = 1'b0;
    tick();
    chk("one_shift", dut.prod_q, 64'h52);
    repeat (3) tick();
    chk("no_extra_shift", dut.prod_q, 64'h52);

    // priority: load beats store
    strctrl = 1'b1; addctrl = 6'd27;
    tick();
    chk("pend_set", {63'd0, dut.pend_q}, 64'd1);
    wrctrl = 1'b1; multiplicand_in = 32'd7; multiplier_in = 32'd9;
    tick();
    wrctrl = 1'b0; strctrl = 1'b0; addctrl = 6'd0;
    chk("prio_prod_q", dut.prod_q, 64'd9);
    chk("prio_pend", {63'd0, dut.pend_q}, 64'd0);
    tick();
    chk("prio_no_shift", dut.prod_q, 64'd9);

    // held ready yields one pulse
    pulses = 0;
    ready = 1'b1;
    repeat (20) begin
      tick();
      if (product_valid) pulses++;
    end
    ready = 1'b0;
    tick();
    chk("held_ready_pulses", 64'(pulses), 64'd1);
    chk("held_ready_product", product, 64'd9);

    // async reset mid-multiply
    load(32'd3, 32'd13);
    run_bits(2);
    saved = dut.prod_q;
    chk("pre_rst_nonzero", {63'd0, saved != 64'd0}, 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("arst_prod_q", dut.prod_q, 64'd0);
    chk("arst_lsb", {63'd0, lsb}, 64'd0);
    chk("arst_product", product, 64'd0);
    chk("arst_valid", {63'd0, product_valid}, 64'd0);
    #3 reset = 1'b1;
    repeat (5) tick();
    chk("post_rst_prod_q", dut.prod_q, 64'd0);
    chk("post_rst_product", product, 64'd0);
    chk("post_rst_valid", {63'd0, product_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
